imem_loader: RTL
================

Name: imem_loader

Overview:
Boot-time writer for instruction memory: accepts a framed byte stream, packs bytes into 32-bit words, and drives the instruction-memory write port that the IFU later reads. Holds the processor in reset until a verified program image has been written, then releases it. Sits between the bench/host byte source and the instruction memory, beside the IFU.

Parameters:
MAX_WORDS, 256, instruction-memory capacity in words; longer images are rejected.
BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-aligned.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a byte this cycle
imem_we  out  1  instruction-memory write enable, one cycle per word
imem_addr  out  32  byte address of the word being written
imem_wdata  out  32  word being written
cpu_rst_n  out  1  processor reset, active-low; 0 until a load completes
busy  out  1  load in progress
done  out  1  image loaded and checksum good
error  out  1  load aborted (length overflow or bad checksum)
words_written  out  16  count of words written in the current or last load

Behaviour:
- Reset is asynchronous (active-low rst_n). Reset values: state IDLE, all outputs 0 (cpu_rst_n=0), internal XOR accumulator 0, byte counter 0, word index 0.
- A byte transfers on a rising edge where in_valid && in_ready. in_ready is combinational from state: 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 otherwise. in_data is ignored when no transfer occurs.
- Frame format: length N as 16 bits, MSB first; then N words, 4 bytes each, MSB first (big-endian); then 1 checksum byte equal to the XOR of all preceding frame bytes.
- States:
  - IDLE: start -> LEN_HI, busy=1.
  - LEN_HI -> LEN_LO after 1 byte.
  - LEN_LO, after its byte:
    - N > MAX_WORDS -> ERROR;
    - N == 0 -> CSUM;
    - else -> DATA.
  - DATA: counts bytes 0..3 and shifts each into the word register. On the 4th byte:
    - in the next cycle, imem_we=1 for exactly one cycle;
    - imem_addr = BASE_ADDR + 4*index; imem_wdata = assembled word;
    - index and words_written increment in that same cycle.
    - in_ready stays 1 during the write cycle, so back-to-back words need no stall.
    - After word N-1 -> CSUM.
  - CSUM: accepted byte == accumulator -> DONE, else -> ERROR.
  - DONE: done=1, cpu_rst_n=1, busy=0.
  - ERROR: error=1, cpu_rst_n=0, busy=0.
- start in DONE or ERROR:
  - clears done, error, words_written, index and the accumulator;
  - drives cpu_rst_n=0 in the next cycle;
  - goes to LEN_HI.
- start while busy is ignored.
- Idle cycles (in_valid=0) in any receiving state: hold all state.
- Address arithmetic is 32-bit unsigned. N ≤ MAX_WORDS guarantees no wrap beyond the memory.
- rst_n low mid-load: immediate abort to IDLE with reset values. Any write not yet issued is dropped.

Decomposition:
- Package loader_pkg holds:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR);
  - constants LEN_BYTES=2, WORD_BYTES=4.
- Natural sub-module: byte_packer, a 4-byte MSB-first shift register plus counter that emits a word_valid pulse.
- FSM, checksum and address logic stay in imem_loader.

Test Plan:
- Minimal image: start; bytes 00 01 20 08 00 05 2C with in_valid held high -> one imem_we pulse with addr 0x00000000, wdata 0x20080005; then done=1, cpu_rst_n=1, words_written=1.
- Gapped stream: N=2, bytes 00 02 20 08 00 05 AC 08 00 04 8F, with in_valid low for 1-3 random cycles between bytes -> writes (0x0, 0x20080005) and (0x4, 0xAC080004); done=1; no extra imem_we pulses.
- Bad checksum: the minimal image with final byte 2D -> the word is still written; error=1, done=0, cpu_rst_n stays 0, in_ready=0.
- Overflow (MAX_WORDS=256): length bytes 01 01 -> error=1 in the cycle after the 2nd byte; imem_we never asserts.
- Empty image: bytes 00 00 00 -> done=1, words_written=0, no writes. A subsequent start drops cpu_rst_n to 0 and reloads the minimal image successfully.
- Reset mid-load: during the minimal image, pull rst_n low after byte 20 08 -> outputs return to reset values asynchronously and no imem_we is issued. After release, a start followed by the full image loads normally.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StDone,
        StError
    } loader_state_e;

    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words and flags the byte completing each word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  in_data,
    output logic [31:0] word_next,
    output logic        word_valid
);

    logic [23:0] word_q;
    logic [1:0]  cnt_q;

    // Completed word as it stands once the current byte is shifted in.
    assign word_next  = {word_q, in_data};
    assign word_valid = shift && (cnt_q == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clear) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift) begin
            word_q <= word_next[23:0];
            cnt_q  <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length/data/checksum frame, writes words into instruction
// memory and holds the CPU in reset until a verified image is in place.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    loader_state_e state_q;
    logic [7:0]    acc_q;
    logic [7:0]    len_hi_q;
    logic [15:0]   len_q;
    logic [15:0]   len_next;
    logic          can_start;
    logic          pk_shift;
    logic          word_valid;
    logic [31:0]   word_next;

    assign in_ready  = state_q inside {StLenHi, StLenLo, StData, StCsum};
    assign len_next  = {len_hi_q, in_data};
    assign can_start = start && (state_q inside {StIdle, StDone, StError});
    assign pk_shift  = in_valid && (state_q == StData);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (can_start),
        .shift      (pk_shift),
        .in_data    (in_data),
        .word_next  (word_next),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            acc_q         <= '0;
            len_hi_q      <= '0;
            len_q         <= '0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            cpu_rst_n     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
        end else begin
            imem_we <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StError: begin
                    if (start) begin
                        state_q       <= StLenHi;
                        acc_q         <= '0;
                        words_written <= '0;
                        cpu_rst_n     <= 1'b0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                    end
                end
                StLenHi: begin
                    if (in_valid) begin
                        len_hi_q <= in_data;
                        acc_q    <= acc_q ^ in_data;
                        state_q  <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (in_valid) begin
                        acc_q <= acc_q ^ in_data;
                        len_q <= len_next;
                        if (32'(len_next) > MAX_WORDS) begin
                            state_q <= StError;
                            error   <= 1'b1;
                            busy    <= 1'b0;
                        end else if (len_next == '0) begin
                            state_q <= StCsum;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (in_valid) begin
                        acc_q <= acc_q ^ in_data;
                    end
                    // Write is registered, so it issues in the cycle after the 4th byte.
                    if (word_valid) begin
                        imem_we       <= 1'b1;
                        imem_addr     <= BASE_ADDR + 32'(WORD_BYTES) * 32'(words_written);
                        imem_wdata    <= word_next;
                        words_written <= words_written + 16'd1;
                        if (words_written + 16'd1 == len_q) begin
                            state_q <= StCsum;
                        end
                    end
                end
                StCsum: begin
                    if (in_valid) begin
                        busy <= 1'b0;
                        if (in_data == acc_q) begin
                            state_q   <= StDone;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state_q <= StError;
                            error   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
